// File: rtl/abs_cmd_exec_pkg.sv
// Shared constants for the abstract register-access responder.
// Holds the cmderr codes, the supported regno window and the FSM encodings.
package abs_cmd_exec_pkg;

   localparam int ABS_DATA_WIDTH = 32;
   localparam int CMD_REGNO_SIZE = 16;
   localparam int ABS_TMO_CYC    = 255;

   localparam logic [2:0] CMDERR_NONE       = 3'd0;
   localparam logic [2:0] CMDERR_BUSY       = 3'd1;
   localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
   localparam logic [2:0] CMDERR_EXCEPTION  = 3'd3;
   localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;
   localparam logic [2:0] CMDERR_OTHER      = 3'd7;

   localparam logic [CMD_REGNO_SIZE-1:0] CSR_REGNO_HI = 16'h0FFF;
   localparam logic [CMD_REGNO_SIZE-1:0] GPR_REGNO_LO = 16'h1000;
   localparam logic [CMD_REGNO_SIZE-1:0] GPR_REGNO_HI = 16'h101F;

   localparam logic [1:0] ABS_IDLE = 2'd0;
   localparam logic [1:0] ABS_REQ  = 2'd1;
   localparam logic [1:0] ABS_DONE = 2'd2;

   // CSRs start at regno 0, so only the upper CSR bound needs checking.
   function automatic logic regno_supported(input logic [CMD_REGNO_SIZE-1:0] r);
      return (r <= CSR_REGNO_HI) || ((r >= GPR_REGNO_LO) && (r <= GPR_REGNO_HI));
   endfunction

endpackage

// File: rtl/abs_cmd_exec.sv
// Hart-side executor for debug abstract register-access commands: drives the
// core's debug register port, returns read data to data0 and tracks busy/cmderr.
module abs_cmd_exec
   import abs_cmd_exec_pkg::*;
#(
   parameter int DATA_WIDTH = ABS_DATA_WIDTH,
   parameter int REGNO_W    = CMD_REGNO_SIZE,
   parameter int TMO_CYC    = ABS_TMO_CYC
) (
   input  logic                  sys_clk,
   input  logic                  sys_rstn,
   input  logic                  cmd_update,
   input  logic                  cmd_type_ok,
   input  logic                  valid_reg_access,
   input  logic                  wr1_rd0,
   input  logic [REGNO_W-1:0]    regno,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  hart_halted,
   input  logic [2:0]            cmderr_w1c,
   output logic                  dbg_reg_req,
   output logic                  dbg_reg_we,
   output logic [REGNO_W-1:0]    dbg_reg_addr,
   output logic [DATA_WIDTH-1:0] dbg_reg_wdata,
   input  logic                  dbg_reg_ack,
   input  logic                  dbg_reg_err,
   input  logic [DATA_WIDTH-1:0] dbg_reg_rdata,
   output logic                  data0_wr_en,
   output logic [DATA_WIDTH-1:0] data0_wr_data,
   output logic                  abs_busy,
   output logic [2:0]            abs_cmderr
);

   localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

   logic [1:0]            state_r, state_s;
   logic [2:0]            cmderr_r, cmderr_s;
   logic [7:0]            tmo_cnt_r;
   logic                  req_r, we_r, busy_r, d0_en_r;
   logic [REGNO_W-1:0]    addr_r;
   logic [DATA_WIDTH-1:0] wdata_r, d0_data_r;
   logic                  accept_s, ack_hit_s, tmo_hit_s;

   // Next state and cmderr; any error set in this cycle overrides a same-cycle clear.
   always_comb begin
      state_s   = state_r;
      cmderr_s  = cmderr_r & ~cmderr_w1c;
      accept_s  = 1'b0;
      ack_hit_s = 1'b0;
      tmo_hit_s = 1'b0;
      case (state_r)
         ABS_IDLE: begin
            if (cmd_update && (cmderr_r == CMDERR_NONE)) begin
               if (!cmd_type_ok) begin
                  cmderr_s = CMDERR_NOTSUP;
               end else if (!valid_reg_access) begin
                  state_s = ABS_IDLE;
               end else if (!hart_halted) begin
                  cmderr_s = CMDERR_HALTRESUME;
               end else if (!regno_supported(regno)) begin
                  cmderr_s = CMDERR_NOTSUP;
               end else begin
                  accept_s = 1'b1;
                  state_s  = ABS_REQ;
               end
            end else begin
               state_s = ABS_IDLE;
            end
         end
         ABS_REQ: begin
            if (cmd_update && (cmderr_r == CMDERR_NONE)) begin
               cmderr_s = CMDERR_BUSY;
            end else begin
               state_s = ABS_REQ;
            end
            // An ack arriving on the timeout cycle still completes the access.
            if (dbg_reg_ack) begin
               ack_hit_s = 1'b1;
               state_s   = ABS_DONE;
               if (dbg_reg_err) begin
                  cmderr_s = CMDERR_EXCEPTION;
               end else begin
                  state_s = ABS_DONE;
               end
            end else if (tmo_cnt_r == TMO_LAST) begin
               tmo_hit_s = 1'b1;
               state_s   = ABS_DONE;
               cmderr_s  = CMDERR_OTHER;
            end else begin
               state_s = ABS_REQ;
            end
         end
         ABS_DONE: begin
            if (cmd_update && (cmderr_r == CMDERR_NONE)) begin
               cmderr_s = CMDERR_BUSY;
            end else begin
               state_s = ABS_IDLE;
            end
            state_s = ABS_IDLE;
         end
         default: begin
            state_s = ABS_IDLE;
         end
      endcase
   end

   // Registered state, port latches, timeout counter and data0 load pulse.
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         state_r   <= ABS_IDLE;
         cmderr_r  <= CMDERR_NONE;
         tmo_cnt_r <= 8'd0;
         req_r     <= 1'b0;
         we_r      <= 1'b0;
         busy_r    <= 1'b0;
         d0_en_r   <= 1'b0;
         addr_r    <= '0;
         wdata_r   <= '0;
         d0_data_r <= '0;
      end else begin
         state_r  <= state_s;
         cmderr_r <= cmderr_s;
         d0_en_r  <= 1'b0;
         if (accept_s) begin
            addr_r    <= regno;
            we_r      <= wr1_rd0;
            wdata_r   <= write_data;
            req_r     <= 1'b1;
            busy_r    <= 1'b1;
            tmo_cnt_r <= 8'd0;
         end
         if (state_r == ABS_REQ) begin
            if (ack_hit_s || tmo_hit_s) begin
               req_r <= 1'b0;
            end else begin
               tmo_cnt_r <= tmo_cnt_r + 8'd1;
            end
            if (ack_hit_s && !dbg_reg_err && !we_r) begin
               d0_en_r   <= 1'b1;
               d0_data_r <= dbg_reg_rdata;
            end
         end
         if (state_r == ABS_DONE) begin
            busy_r <= 1'b0;
         end
      end
   end

   assign dbg_reg_req   = req_r;
   assign dbg_reg_we    = we_r;
   assign dbg_reg_addr  = addr_r;
   assign dbg_reg_wdata = wdata_r;
   assign data0_wr_en   = d0_en_r;
   assign data0_wr_data = d0_data_r;
   assign abs_busy      = busy_r;
   assign abs_cmderr    = cmderr_r;

endmodule

// File: tb/tb_abs_cmd_exec.sv
// Directed bench for abs_cmd_exec: a transaction-level model checked every cycle
// plus literal expectations for the key scenarios.
module tb_abs_cmd_exec;

   localparam int TMO = 255;

   logic        sys_clk = 1'b0;
   logic        sys_rstn;
   logic        cmd_update, cmd_type_ok, valid_reg_access, wr1_rd0, hart_halted;
   logic [15:0] regno;
   logic [31:0] write_data;
   logic [2:0]  cmderr_w1c;
   logic        dbg_reg_req, dbg_reg_we, dbg_reg_ack, dbg_reg_err;
   logic [15:0] dbg_reg_addr;
   logic [31:0] dbg_reg_wdata, dbg_reg_rdata, data0_wr_data;
   logic        data0_wr_en, abs_busy;
   logic [2:0]  abs_cmderr;

   int n_total = 0;
   int n_bad   = 0;
   int busy_cnt = 0, req_cnt = 0, d0_cnt = 0;

   abs_cmd_exec #(.DATA_WIDTH(32), .REGNO_W(16), .TMO_CYC(TMO)) dut (
      .sys_clk(sys_clk), .sys_rstn(sys_rstn), .cmd_update(cmd_update),
      .cmd_type_ok(cmd_type_ok), .valid_reg_access(valid_reg_access),
      .wr1_rd0(wr1_rd0), .regno(regno), .write_data(write_data),
      .hart_halted(hart_halted), .cmderr_w1c(cmderr_w1c),
      .dbg_reg_req(dbg_reg_req), .dbg_reg_we(dbg_reg_we),
      .dbg_reg_addr(dbg_reg_addr), .dbg_reg_wdata(dbg_reg_wdata),
      .dbg_reg_ack(dbg_reg_ack), .dbg_reg_err(dbg_reg_err),
      .dbg_reg_rdata(dbg_reg_rdata), .data0_wr_en(data0_wr_en),
      .data0_wr_data(data0_wr_data), .abs_busy(abs_busy), .abs_cmderr(abs_cmderr)
   );

   always #5 sys_clk = ~sys_clk;

   // Expected visible behaviour of the responder, one entry per clock.
   typedef struct {
      logic        busy, req, we, d0en;
      logic [15:0] addr;
      logic [31:0] wdata, d0data;
      logic [2:0]  cmderr;
      int          waited;
   } m_t;

   m_t m;

   function automatic m_t model_step(input m_t s, input logic cu, tok, vra, wr,
                                     input logic [15:0] rg, input logic [31:0] wd,
                                     input logic hh, input logic [2:0] w1c,
                                     input logic ack, err, input logic [31:0] rd);
      m_t   n = s;
      logic bump;
      n.d0en   = 1'b0;
      n.cmderr = s.cmderr & ~w1c;
      bump     = cu && (s.cmderr == 3'd0);
      if (!s.busy) begin
         if (bump) begin
            if (!tok) n.cmderr = 3'd2;
            else if (!vra) n.cmderr = n.cmderr;
            else if (!hh) n.cmderr = 3'd4;
            else if (!(rg < 16'h1020)) n.cmderr = 3'd2;
            else begin
               n.busy = 1'b1; n.req = 1'b1; n.we = wr;
               n.addr = rg; n.wdata = wd; n.waited = 0;
            end
         end
      end else if (s.req) begin
         if (bump) n.cmderr = 3'd1;
         if (ack) begin
            n.req = 1'b0;
            if (err) n.cmderr = 3'd3;
            else if (!s.we) begin n.d0en = 1'b1; n.d0data = rd; end
         end else begin
            n.waited = s.waited + 1;
            if (n.waited == TMO) begin n.req = 1'b0; n.cmderr = 3'd7; end
         end
      end else begin
         if (bump) n.cmderr = 3'd1;
         n.busy = 1'b0;
      end
      return n;
   endfunction

   always @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) m <= '{default: 0};
      else m <= model_step(m, cmd_update, cmd_type_ok, valid_reg_access, wr1_rd0, regno,
                           write_data, hart_halted, cmderr_w1c, dbg_reg_ack, dbg_reg_err,
                           dbg_reg_rdata);
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Model comparison on the falling edge, away from DUT updates.
   always @(negedge sys_clk) begin
      if (sys_rstn) begin
         check("m_req",    {31'd0, dbg_reg_req},  {31'd0, m.req});
         check("m_busy",   {31'd0, abs_busy},     {31'd0, m.busy});
         check("m_cmderr", {29'd0, abs_cmderr},   {29'd0, m.cmderr});
         check("m_d0en",   {31'd0, data0_wr_en},  {31'd0, m.d0en});
         check("m_d0data", data0_wr_data,         m.d0data);
         check("m_we",     {31'd0, dbg_reg_we},   {31'd0, m.we});
         check("m_addr",   {16'd0, dbg_reg_addr}, {16'd0, m.addr});
         check("m_wdata",  dbg_reg_wdata,         m.wdata);
         busy_cnt <= busy_cnt + (abs_busy ? 1 : 0);
         req_cnt  <= req_cnt + (dbg_reg_req ? 1 : 0);
         d0_cnt   <= d0_cnt + (data0_wr_en ? 1 : 0);
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic send(input logic tok, input logic vra, input logic wr,
                       input logic [15:0] rg, input logic [31:0] wd);
      cmd_update = 1'b1; cmd_type_ok = tok; valid_reg_access = vra;
      wr1_rd0 = wr; regno = rg; write_data = wd;
      tick();
      cmd_update = 1'b0;
   endtask

   task automatic ack_pulse(input logic err, input logic [31:0] rd);
      dbg_reg_ack = 1'b1; dbg_reg_err = err; dbg_reg_rdata = rd;
      tick();
      dbg_reg_ack = 1'b0; dbg_reg_err = 1'b0;
   endtask

   task automatic clear_err(input logic [2:0] bits);
      cmderr_w1c = bits;
      tick();
      cmderr_w1c = 3'd0;
   endtask

   int b0, r0, d0;

   initial begin
      sys_rstn = 1'b0; cmd_update = 1'b0; cmd_type_ok = 1'b0; valid_reg_access = 1'b0;
      wr1_rd0 = 1'b0; regno = 16'd0; write_data = 32'd0; hart_halted = 1'b1;
      cmderr_w1c = 3'd0; dbg_reg_ack = 1'b0; dbg_reg_err = 1'b0; dbg_reg_rdata = 32'd0;
      repeat (3) tick();
      check("rst_busy",   {31'd0, abs_busy}, 32'd0);
      check("rst_req",    {31'd0, dbg_reg_req}, 32'd0);
      check("rst_cmderr", {29'd0, abs_cmderr}, 32'd0);
      sys_rstn = 1'b1;
      tick();

      // Read GPR 0x1005, ack on the fourth request cycle.
      b0 = busy_cnt; d0 = d0_cnt;
      send(1'b1, 1'b1, 1'b0, 16'h1005, 32'd0);
      check("rd_req_start", {31'd0, dbg_reg_req}, 32'd1);
      repeat (3) tick();
      ack_pulse(1'b0, 32'hDEADBEEF);
      check("rd_d0en",   {31'd0, data0_wr_en}, 32'd1);
      check("rd_d0data", data0_wr_data, 32'hDEADBEEF);
      tick(); tick();
      check("rd_busy_len", busy_cnt - b0, 32'd5);
      check("rd_d0_pulses", d0_cnt - d0, 32'd1);
      check("rd_cmderr", {29'd0, abs_cmderr}, 32'd0);

      // Write CSR 0x0300.
      d0 = d0_cnt;
      send(1'b1, 1'b1, 1'b1, 16'h0300, 32'h00001888);
      check("wr_we",    {31'd0, dbg_reg_we}, 32'd1);
      check("wr_addr",  {16'd0, dbg_reg_addr}, 32'h0300);
      check("wr_wdata", dbg_reg_wdata, 32'h00001888);
      tick();
      ack_pulse(1'b0, 32'h12345678);
      tick(); tick();
      check("wr_no_d0", d0_cnt - d0, 32'd0);

      // Command while busy, then ignored command, then clear and retry.
      send(1'b1, 1'b1, 1'b0, 16'h1001, 32'd0);
      tick();
      cmd_update = 1'b1; tick(); cmd_update = 1'b0;
      check("bsy_cmderr", {29'd0, abs_cmderr}, 32'd1);
      check("bsy_req_kept", {31'd0, dbg_reg_req}, 32'd1);
      ack_pulse(1'b0, 32'hCAFEF00D);
      check("bsy_d0data", data0_wr_data, 32'hCAFEF00D);
      tick(); tick();
      send(1'b1, 1'b1, 1'b0, 16'h0005, 32'd0);
      check("ign_busy", {31'd0, abs_busy}, 32'd0);
      clear_err(3'b001);
      check("clr_cmderr", {29'd0, abs_cmderr}, 32'd0);
      send(1'b1, 1'b1, 1'b0, 16'h0005, 32'd0);
      check("retry_busy", {31'd0, abs_busy}, 32'd1);
      tick();
      ack_pulse(1'b0, 32'h00000042);
      check("retry_d0data", data0_wr_data, 32'h00000042);
      tick(); tick();

      // Stray ack while idle must not load data0.
      ack_pulse(1'b0, 32'h55555555);
      check("idle_ack_d0en", {31'd0, data0_wr_en}, 32'd0);

      // Rejections.
      send(1'b1, 1'b1, 1'b0, 16'h2000, 32'd0);
      check("unsup_cmderr", {29'd0, abs_cmderr}, 32'd2);
      check("unsup_req", {31'd0, dbg_reg_req}, 32'd0);
      clear_err(3'b111);
      send(1'b1, 1'b1, 1'b0, 16'h1020, 32'd0);
      check("gpr_edge_hi", {29'd0, abs_cmderr}, 32'd2);
      clear_err(3'b111);
      hart_halted = 1'b0;
      send(1'b1, 1'b1, 1'b0, 16'h1005, 32'd0);
      check("run_cmderr", {29'd0, abs_cmderr}, 32'd4);
      hart_halted = 1'b1;
      clear_err(3'b111);
      send(1'b0, 1'b1, 1'b0, 16'h1005, 32'd0);
      check("type_cmderr", {29'd0, abs_cmderr}, 32'd2);
      clear_err(3'b111);
      send(1'b1, 1'b0, 1'b0, 16'h1005, 32'd0);
      check("notx_busy", {31'd0, abs_busy}, 32'd0);
      check("notx_cmderr", {29'd0, abs_cmderr}, 32'd0);
      send(1'b1, 1'b1, 1'b0, 16'h101F, 32'd0);
      check("gpr_last_ok", {31'd0, abs_busy}, 32'd1);
      ack_pulse(1'b0, 32'h0BADF00D);
      tick(); tick();

      // Timeout: no ack at all.
      r0 = req_cnt;
      send(1'b1, 1'b1, 1'b0, 16'h1000, 32'd0);
      for (int i = 0; i < 400 && dbg_reg_req; i++) tick();
      check("tmo_req_len", req_cnt - r0, TMO);
      check("tmo_cmderr", {29'd0, abs_cmderr}, 32'd7);
      tick();
      clear_err(3'b111);

      // Faulting access.
      d0 = d0_cnt;
      send(1'b1, 1'b1, 1'b0, 16'h0001, 32'd0);
      tick();
      ack_pulse(1'b1, 32'h11111111);
      check("exc_cmderr", {29'd0, abs_cmderr}, 32'd3);
      tick();
      check("exc_no_d0", d0_cnt - d0, 32'd0);
      clear_err(3'b111);

      // Async reset in the middle of a request.
      send(1'b1, 1'b1, 1'b0, 16'h1002, 32'd0);
      cmd_update = 1'b1; tick(); cmd_update = 1'b0;
      #2 sys_rstn = 1'b0;
      #1;
      check("arst_req",    {31'd0, dbg_reg_req}, 32'd0);
      check("arst_busy",   {31'd0, abs_busy}, 32'd0);
      check("arst_cmderr", {29'd0, abs_cmderr}, 32'd0);
      tick();
      sys_rstn = 1'b1;
      tick();
      send(1'b1, 1'b1, 1'b0, 16'h1010, 32'd0);
      tick();
      ack_pulse(1'b0, 32'hA5A5_0001);
      check("post_rst_d0data", data0_wr_data, 32'hA5A5_0001);
      tick(); tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=running want=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/abs_cmd_exec.md
Name: abs_cmd_exec

Overview:
- Hart-side responder for debug-module abstract register-access commands.
- Accepts the decoded access request (valid strobe, write/read flag, regno, write data) and runs it against the hart's GPR/CSR debug port using a req/ack handshake.
- Writes read results back into data0 and maintains the abstractcs busy and cmderr fields.
- Sits between dm_regs/command decode and the core's debug register port.

Parameters:
- DATA_WIDTH, 32, width of data0 and register data.
- REGNO_W, 16, width of regno.
- TMO_CYC, 255, maximum cycles to wait for dbg_reg_ack before aborting (1..255; timeout counter is 8 bits).

Ports:
- sys_clk  in  1  system clock.
- sys_rstn  in  1  asynchronous active-low reset.
- cmd_update  in  1  command register written this cycle (one-cycle pulse).
- cmd_type_ok  in  1  cmdtype == ACCESS_REG_CMD; qualified by cmd_update.
- valid_reg_access  in  1  access-register command with transfer=1, qualified by cmd_update.
- wr1_rd0  in  1  1 = write register, 0 = read register.
- regno  in  REGNO_W  target register number.
- write_data  in  DATA_WIDTH  data0 contents for writes.
- hart_halted  in  1  hart is in debug halt.
- cmderr_w1c  in  3  abstractcs.cmderr write-1-to-clear bits, one-cycle pulse.
- dbg_reg_req  out  1  request to hart register port.
- dbg_reg_we  out  1  write enable, valid with req.
- dbg_reg_addr  out  REGNO_W  latched regno.
- dbg_reg_wdata  out  DATA_WIDTH  latched write data.
- dbg_reg_ack  in  1  hart completes access (one-cycle pulse).
- dbg_reg_err  in  1  access faulted; valid with ack.
- dbg_reg_rdata  in  DATA_WIDTH  read data; valid with ack.
- data0_wr_en  out  1  one-cycle pulse that loads data0.
- data0_wr_data  out  DATA_WIDTH  value to load into data0.
- abs_busy  out  1  abstractcs.busy.
- abs_cmderr  out  3  abstractcs.cmderr.

Behaviour:
- Reset (async, sys_rstn=0): FSM=IDLE. All outputs 0, including cmderr=0 and timeout counter=0.
- cmderr codes: 0 none, 1 busy, 2 not supported, 3 exception, 4 halt/resume, 7 other.
- Supported regno ranges: CSR 0x0000-0x0FFF, GPR 0x1000-0x101F. Anything else is unsupported.
- FSM states: IDLE, REQ, DONE.
- IDLE, cmd_update=1, checks applied in priority order:
  - cmderr!=0: ignore command, no state change.
  - !cmd_type_ok: cmderr<=2.
  - cmd_type_ok && !valid_reg_access (transfer=0): no-op, no error, stay IDLE.
  - !hart_halted: cmderr<=4.
  - regno unsupported: cmderr<=2.
  - Otherwise: latch regno, wr1_rd0 and write_data; set busy and req next cycle; go to REQ.
- REQ:
  - dbg_reg_req=1; addr/we/wdata stable until ack.
  - On ack: req<=0, go to DONE.
    - If err: cmderr<=3 and no data0 write.
    - Else if read: data0_wr_en<=1 and data0_wr_data<=rdata.
  - Timeout counter increments each REQ cycle without ack. On reaching TMO_CYC: req<=0, cmderr<=7, go to DONE.
  - ack in the same cycle as timeout: ack wins.
- DONE: lasts one cycle; data0_wr_en pulse occurs here; busy<=0; go to IDLE.
- Timing: cmd_update in cycle N gives busy=1 and req=1 in N+1. ack in cycle M gives req=0, data0_wr_en=1 in M+1 and busy=0 in M+2.
  - Minimum throughput: one command per 3 cycles.
- cmd_update while busy (REQ/DONE): cmderr<=1 if cmderr==0. The in-flight access continues unaffected.
- cmderr clear:
  - cmderr <= cmderr & ~cmderr_w1c.
  - If a set and a clear occur in the same cycle, the set wins.
  - cmderr holds until cleared.
- hart_halted deasserting during REQ does not abort; the hart must still ack or the access times out.
- dbg_reg_ack outside REQ is ignored.

Decomposition:
- dbg_defines gains:
  - CMDERR_* codes.
  - CSR/GPR regno range bounds.
  - State encodings ABS_IDLE/ABS_REQ/ABS_DONE.
- Width macros come from core_defines (DATA_WIDTH) and dbg_defines (CMD_REGNO_SIZE).
- No sub-module is required. The timeout counter is simple enough to stay inline.

Test Plan:
- Halted hart, read regno 0x1005, ack after 3 cycles with rdata=0xDEADBEEF -> busy high 5 cycles; data0_wr_en pulses with 0xDEADBEEF; cmderr=0.
- Write regno 0x0300 with write_data=0x00001888 -> req has we=1, addr=0x0300, wdata=0x00001888; no data0_wr_en; cmderr=0.
- cmd_update during REQ -> cmderr=1 and the original access completes. A second command with cmderr=1 is ignored. cmderr_w1c=3'b001 -> cmderr=0, and the next command executes.
- Unsupported regno 0x2000 -> cmderr=2, no req. Hart not halted -> cmderr=4. cmd_type_ok=0 -> cmderr=2.
- No ack, TMO_CYC=255 -> req drops after 255 REQ cycles and cmderr=7. Ack with dbg_reg_err=1 -> cmderr=3, no data0 write.
- sys_rstn asserted mid-REQ -> req, busy and cmderr are 0 immediately. After release, a new read completes normally.
